spram_bank_ring: RTL



---
 rtl/spram_bank_ring.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spram_bank_ring.sv
`default_nettype none
// ============================================================================
// Module  : spram_bank_ring
// Brief   : Ring of NUM_BANKS single-port RAM banks with in-order commit and
//           release. Optional macro SPRAM_RING_DROP_CNT_EN builds oDrop_Cnt.
// Revision: 1.0 - initial release
// ============================================================================
module spram_bank_ring #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [ADDR_W-1:0] iWr_Addr,
  input  logic [DATA_W-1:0] iWr_Data,
  input  logic              iWr_En,
  input  logic              iWr_Done,
  output logic              oWr_Ready,
  output logic [2:0]        oWr_Bank,
  input  logic [ADDR_W-1:0] iRd_Addr,
  input  logic              iRd_En,
  input  logic              iRd_Done,
  output logic              oRd_Avail,
  output logic [2:0]        oRd_Bank,
  output logic [DATA_W-1:0] oRd_Data,
  output logic              oRd_Valid,
  output logic [3:0]        oOcc,
  output logic [CNT_W-1:0]  oDrop_Cnt
);

  localparam int             IDX_W      = 3;
  localparam int             MAX_BANKS  = 1 << IDX_W;
  localparam logic [IDX_W-1:0] c_LAST   = IDX_W'(NUM_BANKS - 1);
  localparam logic [3:0]     c_FULL     = 4'(NUM_BANKS);
  localparam logic [3:0]     c_MASKWE   = 4'b1111;
  localparam logic           c_CS       = 1'b1;
  localparam logic           c_STDBY    = 1'b0;
  localparam logic           c_SLEEP    = 1'b0;
  localparam logic           c_PWROFF_N = 1'b1;
  localparam logic           c_RAM_ON   = c_CS & ~c_STDBY & ~c_SLEEP & c_PWROFF_N;

  logic [IDX_W-1:0]  r_wrIdx, r_rdIdx;
  logic [3:0]        r_occ;
  logic              w_wrReady, w_rdAvail, w_wrAccept, w_rdAccept, w_commit, w_release;

  logic              r_wrWe;
  logic [IDX_W-1:0]  r_wrBank;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [DATA_W-1:0] r_wrData;

  logic              r_rdReq, r_rdValid;
  logic [IDX_W-1:0]  r_rdBankS1, r_rdBankS2;
  logic [ADDR_W-1:0] r_rdAddr;
  logic [DATA_W-1:0] w_bankQ [MAX_BANKS];

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
    return (idx == c_LAST) ? '0 : idx + 1'b1;
  endfunction

  assign w_wrReady  = (r_occ < c_FULL);
  assign w_rdAvail  = (r_occ != 4'd0);
  assign w_wrAccept = iWr_En   & w_wrReady;
  assign w_commit   = iWr_Done & w_wrReady;
  assign w_rdAccept = iRd_En   & w_rdAvail;
  assign w_release  = iRd_Done & w_rdAvail;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wrIdx <= '0;
      r_rdIdx <= '0;
      r_occ   <= '0;
    end else begin
      if (w_commit)  r_wrIdx <= nextIdx(r_wrIdx);
      if (w_release) r_rdIdx <= nextIdx(r_rdIdx);
      case ({w_commit, w_release})
        2'b10:   r_occ <= r_occ + 4'd1;
        2'b01:   r_occ <= r_occ - 4'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Bank index travels with each access so in-flight work survives index moves
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wrWe     <= 1'b0;
      r_wrBank   <= '0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
      r_rdReq    <= 1'b0;
      r_rdBankS1 <= '0;
      r_rdAddr   <= '0;
      r_rdValid  <= 1'b0;
      r_rdBankS2 <= '0;
    end else begin
      r_wrWe     <= w_wrAccept;
      r_wrBank   <= r_wrIdx;
      r_wrAddr   <= iWr_Addr;
      r_wrData   <= iWr_Data;
      r_rdReq    <= w_rdAccept;
      r_rdBankS1 <= r_rdIdx;
      r_rdAddr   <= iRd_Addr;
      r_rdValid  <= r_rdReq;
      if (r_rdReq) r_rdBankS2 <= r_rdBankS1;
    end
  end

  for (genvar gb = 0; gb < MAX_BANKS; gb++) begin : g_bank
    if (gb < NUM_BANKS) begin : g_ram
      logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
      logic [DATA_W-1:0] r_q;
      logic              w_we, w_re;
      logic [ADDR_W-1:0] w_ad;

      assign w_we = c_RAM_ON & (&c_MASKWE) & r_wrWe & (r_wrBank == IDX_W'(gb));
      assign w_re = c_RAM_ON & r_rdReq & (r_rdBankS1 == IDX_W'(gb)) & ~w_we;
      assign w_ad = w_we ? r_wrAddr : r_rdAddr;

      always_ff @(posedge iClk) begin
        if (w_we) mem[w_ad] <= r_wrData;
      end

      // Output register only moves on a read, which gives oRd_Data its hold
      always_ff @(posedge iClk) begin
        if (iRst)      r_q <= '0;
        else if (w_re) r_q <= mem[w_ad];
      end

      assign w_bankQ[gb] = r_q;
    end else begin : g_none
      assign w_bankQ[gb] = '0;
    end
  end

  assign oWr_Ready = w_wrReady;
  assign oWr_Bank  = r_wrIdx;
  assign oRd_Avail = w_rdAvail;
  assign oRd_Bank  = r_rdIdx;
  assign oOcc      = r_occ;
  assign oRd_Valid = r_rdValid;
  assign oRd_Data  = w_bankQ[r_rdBankS2];

`ifdef SPRAM_RING_DROP_CNT_EN
  logic [CNT_W-1:0] r_dropCnt;
  always_ff @(posedge iClk) begin
    if (iRst)                                      r_dropCnt <= '0;
    else if (iWr_En && !w_wrReady && ~&r_dropCnt)  r_dropCnt <= r_dropCnt + 1'b1;
  end
  assign oDrop_Cnt = r_dropCnt;
`else
  assign oDrop_Cnt = '0;
`endif

endmodule
`default_nettype wire
